i2c_responder: RTL and testbench

- Synthesizable I2C write-only responder that models the WM8731 codec control port. It is the far end of the codec-configuration I2C link that the design's I2C initiator drives.
- It samples SCL and SDA on CLK50 and ACKs correctly addressed 3-byte frames. It holds a 9-bit-wide codec register file and exposes committed writes and a read port.
- Used for on-board loopback through GPIO and as a bench target for the initiator.

---
 rtl/i2c_responder_pkg.sv | 49 ++++
 rtl/i2c_responder_if.sv | 12 +
 rtl/i2c_bus_sync.sv | 54 +++++
 rtl/i2c_responder.sv | 180 ++++++++++++++++++
 tb/tb_i2c_responder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_responder_pkg.sv
// Shared definitions for the WM8731-style I2C write-only responder.
// Contents: FSM state enum, device address default, codec register index
// constants and the power-on default value of each register.
package i2c_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_REG,
        ST_ACK_REG,
        ST_DATA,
        ST_ACK_DATA,
        ST_IGNORE
    } state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

    // Implemented codec registers R0..R9; 15 is the write-only RESET register.
    localparam int NUM_REGS = 10;
    localparam logic [6:0] REG_R0 = 7'd0;
    localparam logic [6:0] REG_R1 = 7'd1;
    localparam logic [6:0] REG_R2 = 7'd2;
    localparam logic [6:0] REG_R3 = 7'd3;
    localparam logic [6:0] REG_R4 = 7'd4;
    localparam logic [6:0] REG_R5 = 7'd5;
    localparam logic [6:0] REG_R6 = 7'd6;
    localparam logic [6:0] REG_R7 = 7'd7;
    localparam logic [6:0] REG_R8 = 7'd8;
    localparam logic [6:0] REG_R9 = 7'd9;
    localparam logic [6:0] REG_RESET = 7'd15;

    function automatic logic [8:0] reg_default(input logic [3:0] idx);
        logic [8:0] val;
        case (idx)
            4'd0:    val = 9'h097;
            4'd1:    val = 9'h097;
            4'd2:    val = 9'h079;
            4'd3:    val = 9'h079;
            4'd4:    val = 9'h00A;
            4'd5:    val = 9'h008;
            4'd6:    val = 9'h09F;
            4'd7:    val = 9'h00A;
            default: val = 9'h000;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_responder_if.sv
// I2C wire bundle between an initiator and the responder.
//   I2C_SCLK    : bus clock driven by the initiator
//   I2C_SDAT_IN : resolved SDA level as seen on the wire
//   sdat_oe     : responder open-drain enable (1 = pull SDA low)
interface i2c_responder_if;
    logic I2C_SCLK;
    logic I2C_SDAT_IN;
    logic sdat_oe;

    modport slave  (input I2C_SCLK, input I2C_SDAT_IN, output sdat_oe);
    modport master (output I2C_SCLK, output I2C_SDAT_IN, input sdat_oe);
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the CLK50 domain and detects bus events.
// Ports:
//   CLK50, RESET_KEY       : clock, async active-low reset
//   scl_pin, sda_pin       : raw bus levels
//   scl_rise, scl_fall     : one-cycle pulses on synchronized SCL edges
//   start, stop            : one-cycle pulses for START / STOP conditions
//   sda_s                  : synchronized SDA level
// SYNC_STAGES must be at least 2.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK50,
    input  logic RESET_KEY,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Reset to 1 so the idle bus level produces no spurious edge.
    always_ff @(posedge CLK50 or negedge RESET_KEY) begin
        if (!RESET_KEY) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_pin};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_pin};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    // START/STOP need SCL high and stable across both samples, so an SDA
    // change coinciding with an SCL edge is treated as an SCL edge only.
    assign start = scl_s & scl_d & sda_d & ~sda_s;
    assign stop  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_responder.sv
// Write-only I2C responder modelling the WM8731 codec control port.
// Accepts 3-byte frames {addr+W, reg_addr[6:0]+data[8], data[7:0]}.
// Ports:
//   CLK50, RESET_KEY : 50 MHz clock, async active-low reset
//   bus (slave)      : I2C_SCLK, I2C_SDAT_IN in; sdat_oe out (ACK pull-down)
//   rd_addr/rd_data  : combinational register-file read (0 above R9)
//   wr_strobe        : one-cycle valid for a committed write; there is no
//                      ready, the consumer must take wr_addr/wr_data then
//   wr_addr/wr_data  : address and data of the last committed write
//   nack_count       : saturating count of NACKed bytes
//   busy             : high from START until STOP/abort
//   state_dbg        : current FSM state
module i2c_responder
    import i2c_responder_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  CLK50,
    input  logic                  RESET_KEY,
    i2c_responder_if.slave        bus,
    input  logic [3:0]            rd_addr,
    output logic [8:0]            rd_data,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic [8:0]            wr_data,
    output logic [7:0]            nack_count,
    output logic                  busy,
    output state_t                state_dbg
);

    logic scl_rise, scl_fall, start, stop, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK50    (CLK50),
        .RESET_KEY(RESET_KEY),
        .scl_pin  (bus.I2C_SCLK),
        .sda_pin  (bus.I2C_SDAT_IN),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda_s    (sda_s)
    );

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic        oe_q, oe_n;
    logic        rise_seen;
    logic        bit_fall;
    logic        commit, nack_inc, latch_reg;
    logic [7:0]  shift;
    logic [6:0]  reg_addr;
    logic        data_msb;
    logic [8:0]  commit_data;
    logic [8:0]  regs [NUM_REGS];

    // The SCL fall that follows a START is not the end of a bit; only a fall
    // preceded by a rise in the current bit advances the counter.
    assign bit_fall    = scl_fall & rise_seen;
    assign commit_data = {data_msb, shift[6:0], sda_s};

    always_ff @(posedge CLK50 or negedge RESET_KEY) begin
        if (!RESET_KEY) begin
            state   <= ST_IDLE;
            bit_cnt <= 4'd0;
            oe_q    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            oe_q    <= oe_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        oe_n      = oe_q;
        commit    = 1'b0;
        nack_inc  = 1'b0;
        latch_reg = 1'b0;
        if (start) begin
            state_n   = ST_ADDR;
            bit_cnt_n = 4'd0;
            oe_n      = 1'b0;
        end else if (stop) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 4'd0;
            oe_n      = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_REG, ST_DATA: begin
                    if (state == ST_DATA && scl_rise && bit_cnt == 4'd7)
                        commit = 1'b1;
                    if (bit_fall) begin
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = 4'd8;
                            if (state == ST_ADDR) begin
                                if (shift == {DEV_ADDR, 1'b0}) begin
                                    state_n = ST_ACK_ADDR;
                                    oe_n    = 1'b1;
                                end else begin
                                    // Enter IGNORE at bit 8 so the NACK is
                                    // counted on this byte's 9th rise.
                                    state_n = ST_IGNORE;
                                end
                            end else if (state == ST_REG) begin
                                state_n   = ST_ACK_REG;
                                oe_n      = 1'b1;
                                latch_reg = 1'b1;
                            end else begin
                                state_n = ST_ACK_DATA;
                                oe_n    = 1'b1;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt + 4'd1;
                        end
                    end
                end
                ST_ACK_ADDR, ST_ACK_REG, ST_ACK_DATA: begin
                    if (bit_fall) begin
                        oe_n      = 1'b0;
                        bit_cnt_n = 4'd0;
                        if (state == ST_ACK_ADDR)     state_n = ST_REG;
                        else if (state == ST_ACK_REG) state_n = ST_DATA;
                        else                          state_n = ST_IGNORE;
                    end
                end
                ST_IGNORE: begin
                    if (scl_rise && bit_cnt == 4'd8)
                        nack_inc = 1'b1;
                    if (bit_fall)
                        bit_cnt_n = (bit_cnt == 4'd8) ? 4'd0 : bit_cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK50 or negedge RESET_KEY) begin
        if (!RESET_KEY) begin
            rise_seen  <= 1'b0;
            shift      <= 8'd0;
            reg_addr   <= 7'd0;
            data_msb   <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_addr    <= 7'd0;
            wr_data    <= 9'd0;
            nack_count <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= reg_default(4'(i));
        end else begin
            wr_strobe <= commit;
            if (start || stop || scl_fall) rise_seen <= 1'b0;
            else if (scl_rise)              rise_seen <= 1'b1;
            if (scl_rise)
                shift <= {shift[6:0], sda_s};
            if (latch_reg)
                {reg_addr, data_msb} <= shift;
            if (nack_inc && nack_count != 8'hFF)
                nack_count <= nack_count + 8'd1;
            if (commit) begin
                wr_addr <= reg_addr;
                wr_data <= commit_data;
                if (reg_addr == REG_RESET) begin
                    for (int i = 0; i < NUM_REGS; i++)
                        regs[i] <= reg_default(4'(i));
                end else if (reg_addr < 7'(NUM_REGS)) begin
                    regs[reg_addr[3:0]] <= commit_data;
                end
            end
        end
    end

    assign rd_data     = (rd_addr < 4'(NUM_REGS)) ? regs[rd_addr] : 9'd0;
    assign bus.sdat_oe = oe_q;
    assign busy        = (state != ST_IDLE);
    assign state_dbg   = state;

endmodule

// File: tb/tb_i2c_responder.sv
// Directed bench for i2c_responder: an open-drain I2C initiator model drives
// frames, expected commits go into exp_q and a monitor checks every
// wr_strobe against it.
module tb_i2c_responder;
    import i2c_responder_pkg::*;

    localparam int Q = 6;  // CLK50 cycles per quarter of an SCL bit

    logic        CLK50;
    logic        RESET_KEY;
    logic        m_scl;
    logic        m_sda;
    logic [3:0]  rd_addr;
    logic [8:0]  rd_data;
    logic        wr_strobe;
    logic [6:0]  wr_addr;
    logic [8:0]  wr_data;
    logic [7:0]  nack_count;
    logic        busy;
    state_t      state_dbg;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    i2c_responder_if bus();
    assign bus.I2C_SCLK    = m_scl;
    assign bus.I2C_SDAT_IN = m_sda & ~bus.sdat_oe;

    i2c_responder dut (
        .CLK50     (CLK50),
        .RESET_KEY (RESET_KEY),
        .bus       (bus),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .nack_count(nack_count),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    initial CLK50 = 1'b0;
    always #10 CLK50 = ~CLK50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] exp_default(input int idx);
        case (idx)
            0, 1:    return 9'h097;
            2, 3:    return 9'h079;
            4:       return 9'h00A;
            5:       return 9'h008;
            6:       return 9'h09F;
            7:       return 9'h00A;
            default: return 9'h000;
        endcase
    endfunction

    // Scoreboard monitor
    always @(negedge CLK50) begin
        if (RESET_KEY === 1'b1 && wr_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected: got addr=0x%0h data=0x%0h, expected none",
                         wr_addr, wr_data);
            end else begin
                check("commit", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic wait_q();
        repeat (Q) @(posedge CLK50);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        ack = ~bus.I2C_SDAT_IN;
        wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic frame3(input logic [7:0] a, input logic [7:0] r, input logic [7:0] d);
        logic ack;
        i2c_start();
        send_byte(a, ack); check("ack_addr", ack, 1);
        send_byte(r, ack); check("ack_reg", ack, 1);
        send_byte(d, ack); check("ack_data", ack, 1);
        i2c_stop();
    endtask

    task automatic read_check(input string name, input logic [3:0] idx, input logic [8:0] exp);
        rd_addr = idx;
        #1;
        check(name, rd_data, exp);
    endtask

    initial begin
        logic ack;
        RESET_KEY = 1'b0;
        m_scl     = 1'b1;
        m_sda     = 1'b1;
        rd_addr   = 4'd0;
        repeat (5) @(posedge CLK50);
        #1;
        check("rst_sdat_oe", bus.sdat_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_nack", nack_count, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        RESET_KEY = 1'b1;
        wait_q();
        for (int i = 0; i < 16; i++) read_check("rd_default", 4'(i), exp_default(i));

        // Write R6 = 0x000
        exp_q.push_back({7'h06, 9'h000});
        frame3(8'h34, 8'h0C, 8'h00);
        check("t1_busy_after_stop", busy, 0);
        read_check("t1_rd6", 4'd6, 9'h000);
        check("t1_nack", nack_count, 0);

        // Write R4, then RESET register restores defaults
        exp_q.push_back({7'h04, 9'h012});
        frame3(8'h34, 8'h08, 8'h12);
        read_check("t2_rd4", 4'd4, 9'h012);
        exp_q.push_back({7'h0F, 9'h000});
        frame3(8'h34, 8'h1E, 8'h00);
        read_check("t2_rd4_default", 4'd4, 9'h00A);
        read_check("t2_rd6_default", 4'd6, 9'h09F);
        check("t2_wr_addr", wr_addr, 15);

        // Wrong address: NACK, then a valid frame still ACKed
        i2c_start();
        check("t3_busy", busy, 1);
        send_byte(8'h36, ack);
        check("t3_ack_bad_addr", ack, 0);
        i2c_stop();
        check("t3_nack", nack_count, 1);
        exp_q.push_back({7'h05, 9'h055});
        frame3(8'h34, 8'h0A, 8'h55);
        read_check("t3_rd5", 4'd5, 9'h055);

        // Extra 4th byte is NACKed, single commit
        exp_q.push_back({7'h07, 9'h001});
        i2c_start();
        send_byte(8'h34, ack); check("t4_ack_addr", ack, 1);
        send_byte(8'h0E, ack); check("t4_ack_reg", ack, 1);
        send_byte(8'h01, ack); check("t4_ack_data", ack, 1);
        send_byte(8'hFF, ack); check("t4_ack_extra", ack, 0);
        i2c_stop();
        check("t4_nack", nack_count, 2);
        read_check("t4_rd7", 4'd7, 9'h001);

        // Repeated START after the REG byte aborts that frame
        i2c_start();
        send_byte(8'h34, ack); check("t5_ack_addr", ack, 1);
        send_byte(8'h02, ack); check("t5_ack_reg", ack, 1);
        exp_q.push_back({7'h00, 9'h197});
        frame3(8'h34, 8'h01, 8'h97);
        read_check("t5_rd0", 4'd0, 9'h197);
        read_check("t5_rd1", 4'd1, 9'h097);

        // Reset in the middle of the DATA byte
        i2c_start();
        send_byte(8'h34, ack); check("t6_ack_addr", ack, 1);
        send_byte(8'h10, ack); check("t6_ack_reg", ack, 1);
        for (int i = 7; i >= 4; i--) send_bit(1'b1);
        m_scl = 1'b1;
        wait_q();
        RESET_KEY = 1'b0;
        #1;
        check("t6_sdat_oe", bus.sdat_oe, 0);
        check("t6_busy", busy, 0);
        check("t6_nack", nack_count, 0);
        read_check("t6_rd0_default", 4'd0, 9'h097);
        read_check("t6_rd8", 4'd8, 9'h000);
        m_sda = 1'b1;
        wait_q();
        RESET_KEY = 1'b1;
        wait_q(); wait_q();
        check("t6_busy_after", busy, 0);
        check("t6_wr_addr", wr_addr, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
